// File: rtl/pus_feeder_if.sv
// pus_feeder_if: input beat stream feeding the PU vector loader.
//
// Handshake: a beat transfers on a rising clk edge where s_valid && s_ready.
// The source holds s_data stable while s_valid is high and s_ready is low.
// The sink may raise s_ready without looking at s_valid.
//
// Signals:
//   s_valid  source -> sink  beat valid
//   s_ready  sink -> source  sink can take a beat this cycle
//   s_data   source -> sink  packed pair, low half = even word, high half = odd word
//
// Modports:
//   master  the beat source (DMA front end or testbench driver)
//   slave   the beat sink (pus_feeder)
interface pus_feeder_if #(
    parameter int data_width = 16
) ();

    logic                      s_valid;
    logic                      s_ready;
    logic [2*data_width-1:0]   s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/pus_feeder.sv
// pus_feeder: write-side driver for the img2col PU vector.
//
// Takes a stream of packed pixel pairs and loads each PU register file in
// turn. Each accepted beat becomes one paired write, visible one cycle later:
// start is one-hot on the target PU, new1/new2 carry the even/odd words and
// adrs_in1/adrs_in2 the matching even/odd register addresses. Once every PU
// holds reg_num words, round pulses on all PUs, then done pulses.
//
// Ports:
//   clk       system clock, rising edge
//   nrst      asynchronous reset, active-high
//   go        frame start request, only looked at in IDLE
//   s         beat stream (pus_feeder_if.slave)
//   start     one-hot PU write enable
//   round     compute/shift trigger, all PUs at once
//   new1      even word, written at adrs_in1
//   new2      odd word, written at adrs_in2
//   adrs_in1  even register address
//   adrs_in2  odd register address
//   busy      high from go acceptance until after done
//   done      one-cycle end-of-frame pulse
//   state_dbg current FSM state (IDLE=0, LOAD=1, ROUND=2, DONE=3)
module pus_feeder #(
    parameter int row         = 28,
    parameter int data_width  = 16,
    parameter int address_num = 5,
    parameter int reg_num     = 20
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   go,
    pus_feeder_if.slave            s,
    output logic [row-1:0]         start,
    output logic [row-1:0]         round,
    output logic [data_width-1:0]  new1,
    output logic [data_width-1:0]  new2,
    output logic [address_num-1:0] adrs_in1,
    output logic [address_num-1:0] adrs_in2,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             state_dbg
);

    // Each beat carries two words, so a PU needs reg_num/2 beats.
    localparam int half = reg_num / 2;
    localparam int pu_w = (row > 1) ? $clog2(row) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [pu_w-1:0]        pu_idx;
    logic [address_num-1:0] beat_idx;
    logic                   accept;
    logic                   beat_wrap;
    logic                   last_pu;
    logic                   last_beat;
    logic                   ready_c;

    assign state_dbg = state;

    assign accept    = s.s_valid && (state == LOAD);
    assign beat_wrap = (beat_idx == address_num'(half - 1));
    assign last_pu   = (pu_idx == pu_w'(row - 1));
    assign last_beat = accept && beat_wrap && last_pu;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and s_ready. s_ready depends on state only, so the
    // source can never build a combinational loop through s_valid.
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        ready_c = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                ready_c = 1'b1;
                if (last_beat) begin
                    state_n = ROUND;
                end
            end
            ROUND: begin
                state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign s.s_ready = ready_c;

    // ------------------------------------------------------------------
    // Position counters: beat_idx walks the register pairs of one PU,
    // pu_idx advances when a PU is full. Bubbles simply hold them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            pu_idx   <= '0;
            beat_idx <= '0;
        end else if (state == IDLE && go) begin
            pu_idx   <= '0;
            beat_idx <= '0;
        end else if (accept) begin
            if (beat_wrap) begin
                beat_idx <= '0;
                pu_idx   <= last_pu ? '0 : pu_idx + pu_w'(1);
            end else begin
                beat_idx <= beat_idx + address_num'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // PU write port. start is a strobe; the data and address lines hold
    // their last values between strobes since the PU ignores them then.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            start    <= '0;
            new1     <= '0;
            new2     <= '0;
            adrs_in1 <= '0;
            adrs_in2 <= '0;
        end else begin
            start <= accept ? (row'(1) << pu_idx) : '0;
            if (accept) begin
                new1     <= s.s_data[data_width-1:0];
                new2     <= s.s_data[2*data_width-1:data_width];
                // reg_num <= 2**address_num, so the doubled index fits.
                adrs_in1 <= address_num'(beat_idx << 1);
                adrs_in2 <= address_num'(beat_idx << 1) | address_num'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame control outputs. round is registered off the ROUND state so
    // it lands the cycle after the final start strobe, never with it;
    // done follows one cycle later from the DONE state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            round <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            round <= (state == ROUND) ? '1 : '0;
            done  <= (state == DONE);
            // Set on go acceptance, cleared the cycle after the done pulse.
            busy  <= (state == IDLE && go) || (busy && !done);
        end
    end

endmodule

// File: doc/pus_feeder.md
Name: pus_feeder

Overview:
- Write-side driver for the img2col PU vector.
- Accepts a stream of packed pixel pairs from the AXI side and loads each PU's register file in turn. It drives the one-hot start vector, the paired write addresses and data words, then pulses round for the whole vector.
- Sits between the AXI read/DMA front end and the PU vector. One frame loads row*reg_num words.

Parameters:
- row, 28: number of PUs in the vector; width of start/round.
- data_width, 16: width of one pixel word.
- address_num, 5: width of the PU register address.
- reg_num, 20: registers per PU. Must be even and ≤ 2^address_num.

Ports:
- clk  input  1  system clock, rising edge.
- nrst  input  1  asynchronous reset, active-high (asserted = 1).
- go  input  1  frame start request, sampled in IDLE only.
- s_valid  input  1  input beat valid.
- s_ready  output  1  input beat accepted when s_valid && s_ready.
- s_data  input  2*data_width  packed pair: [data_width-1:0] = even word, upper half = odd word.
- start  output  row  one-hot write enable, one bit per PU.
- round  output  row  compute/shift trigger per PU.
- new1  output  data_width  even word to PU.
- new2  output  data_width  odd word to PU.
- adrs_in1  output  address_num  write address for new1.
- adrs_in2  output  address_num  write address for new2.
- busy  output  1  high from go acceptance until done.
- done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (nrst=1, async): state=IDLE; start, round, new1, new2, adrs_in1, adrs_in2, busy, done, s_ready all 0; pu_idx and beat_idx both 0.
- FSM states: IDLE, LOAD, ROUND, DONE.
- IDLE:
  - s_ready=0.
  - go=1 → LOAD next cycle, busy=1, counters cleared.
  - go in any other state is ignored.
- LOAD:
  - s_ready=1, combinational from state only; does not depend on s_valid.
  - Each accepted beat at cycle t, registered and visible at t+1:
    - start = 1<<pu_idx
    - new1 = s_data low half
    - new2 = s_data high half
    - adrs_in1 = 2*beat_idx
    - adrs_in2 = 2*beat_idx+1
- Output hold when no beat was accepted at t:
  - start=0 at t+1.
  - new1/new2/adrs_in1/adrs_in2 hold their last values.
  - PU ignores them while start=0.
- Counters, per accepted beat:
  - beat_idx increments and wraps to 0 after reg_num/2-1.
  - On wrap, pu_idx increments.
  - The beat with pu_idx=row-1 and beat_idx=reg_num/2-1 is the last beat: → ROUND next cycle; s_ready drops the cycle after the last beat is accepted.
- Bubbles: s_valid=0 holds all counters; no partial-PU timeout.
- ROUND:
  - Exactly one cycle, round = all ones (row bits), start=0.
  - The last LOAD write (start[row-1]) appears in the same cycle that the FSM enters ROUND. round therefore asserts the cycle after the final start pulse, never overlapping it.
- DONE: one cycle, done=1, busy=0 from next cycle, round=0 → IDLE.
- Latency:
  - go → s_ready: 1 cycle.
  - Accepted beat → PU write strobe: 1 cycle.
  - Last beat → round: 2 cycles.
  - Last beat → done: 3 cycles.
- Full frame with no bubbles: row*reg_num/2 LOAD cycles + 1 ROUND + 1 DONE.
- Reset mid-operation: immediate return to reset values; the partially loaded frame is abandoned and no round or done pulse is issued.
- Address arithmetic: 2*beat_idx computed in address_num bits; reg_num ≤ 2^address_num guarantees no overflow.

Test Plan:
- Reset, then go with 280 contiguous beats, s_data = {odd=2k+1, even=2k} → start[0] high for 10 cycles with adrs_in1=0,2..18 and adrs_in2=1,3..19; start[27] last; round=28'hFFFFFFF once 2 cycles after the last beat; done 1 cycle later.
- s_valid toggled 1/0 every cycle → start pulses only one cycle after accepted beats; addresses advance only on acceptance; total frame takes 560 LOAD cycles; round/done timing unchanged relative to the last beat.
- go held high through an entire frame → exactly one frame runs; after DONE a new frame starts from IDLE with pu_idx=0 and beat_idx=0.
- nrst asserted mid-frame after beat 55 (pu_idx=5, beat_idx=5) → all outputs 0 asynchronously, no round or done; next go restarts at start[0], adrs_in1=0.
- s_valid=1 in IDLE without go → s_ready=0, start stays 0, no writes.
- Boundary: the beat that moves from PU 0 to PU 1 → start goes 28'h1 to 28'h2 on consecutive cycles, and adrs_in1 goes 18 to 0.
